// File: rtl/gbm_pkg.sv
// gbm_pkg -- shared types for the GBM path engine.
//   word_t     : signed fixed-point word at the default 32-bit width
//   lane_vec_t : packed vector of LANE_N words, lane 0 in the LSBs
//   state_t    : step-sequencer states
//   SAT_MAX/SAT_MIN : clamp limits applied when GBM_SAT_EN is defined
`timescale 1ns/1ps
package gbm_pkg;
  localparam int WORD_W = 32;
  localparam int LANE_N = 4;

  typedef logic signed [WORD_W-1:0] word_t;
  typedef word_t [LANE_N-1:0] lane_vec_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL1 = 2'd1,
    MUL2 = 2'd2,
    OUT  = 2'd3
  } state_t;

  localparam word_t SAT_MAX = word_t'({1'b0, {(WORD_W-1){1'b1}}});
  localparam word_t SAT_MIN = '0;
endpackage

// File: rtl/gbm_fx_mul.sv
// gbm_fx_mul -- signed fixed-point multiplier, p = (a*b) >>> QFRAC
// truncated to WIDTH bits, delivered MUL_LAT clocks after a/b are presented.
// Ports:
//   clk      : clock
//   a, b     : signed WIDTH-bit operands
//   p        : signed WIDTH-bit product, MUL_LAT-cycle latency
`timescale 1ns/1ps
module gbm_fx_mul #(
  parameter int WIDTH   = 32,
  parameter int QFRAC   = 16,
  parameter int MUL_LAT = 2
) (
  input  logic                    clk,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] p
);
  logic signed [2*WIDTH-1:0] a_w;
  logic signed [2*WIDTH-1:0] b_w;
  logic signed [WIDTH-1:0]   pipe_q [MUL_LAT];

  // Sign-extend so the full 2*WIDTH-bit product is formed before the shift.
  assign a_w = (2*WIDTH)'(a);
  assign b_w = (2*WIDTH)'(b);

  // NOTE: pure datapath pipeline -- no reset; the sequencer only samples it
  // after a full MUL_LAT of stable operands, so stale contents never escape.
  always_ff @(posedge clk) begin
    pipe_q[0] <= WIDTH'((a_w * b_w) >>> QFRAC);
    for (int k = 1; k < MUL_LAT; k++) begin
      pipe_q[k] <= pipe_q[k-1];
    end
  end

  assign p = pipe_q[MUL_LAT-1];
endmodule

// File: rtl/gbm_path_engine.sv
// gbm_path_engine -- LANES geometric-Brownian-motion paths stepped in lockstep:
//   inc = drift + ((vol*z) >>> QFRAC);  S' = S + ((S*inc) >>> QFRAC)
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   cfg_we, cfg_drift, cfg_vol    : config write (taken only when idle, no path)
//   start_valid/ready, s0         : start a path with per-lane initial prices
//   z_valid/ready, z              : per-step normal draws, one per lane
//   out_valid/ready, s_out,
//   out_step, out_last            : per-step result; last step ends the path
//   busy                          : sequencer not in IDLE
//   sat_flag                      : sticky per-lane clamp indicator
// Build option: define GBM_SAT_EN to clamp S' into [0, max positive] and
// flag clamps; otherwise S' wraps and sat_flag reads 0.
`timescale 1ns/1ps
module gbm_path_engine
  import gbm_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int QFRAC   = 16,
  parameter int LANES   = 4,
  parameter int N_STEPS = 64,
  parameter int MUL_LAT = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_we,
  input  logic [WIDTH-1:0]           cfg_drift,
  input  logic [WIDTH-1:0]           cfg_vol,
  input  logic                       start_valid,
  output logic                       start_ready,
  input  logic [LANES*WIDTH-1:0]     s0,
  input  logic                       z_valid,
  output logic                       z_ready,
  input  logic [LANES*WIDTH-1:0]     z,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*WIDTH-1:0]     s_out,
  output logic [$clog2(N_STEPS)-1:0] out_step,
  output logic                       out_last,
  output logic                       busy,
  output logic [LANES-1:0]           sat_flag
);
  localparam int SW = $clog2(N_STEPS);
  localparam int LW = $clog2(MUL_LAT + 1);

  state_t                  state_q, state_d;
  logic                    active_q;
  logic [SW-1:0]           step_q;
  logic [LW-1:0]           lat_q;
  logic signed [WIDTH-1:0] cfg_drift_q, cfg_vol_q;

  logic lat_done, start_fire, z_fire, out_fire, capture;

  assign start_ready = (state_q == IDLE) && !active_q;
  assign z_ready     = (state_q == IDLE) && active_q;
  assign out_valid   = (state_q == OUT);
  assign busy        = (state_q != IDLE);
  assign start_fire  = start_valid && start_ready;
  assign z_fire      = z_valid && z_ready;
  assign out_fire    = out_valid && out_ready;
  assign lat_done    = (lat_q == LW'(MUL_LAT - 1));
  // Result is registered on the last MUL2 cycle, when the second product lands.
  assign capture     = (state_q == MUL2) && lat_done;
  assign out_step    = step_q;
  assign out_last    = (step_q == SW'(N_STEPS - 1));

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (z_fire)    state_d = MUL1;
      MUL1: if (lat_done)  state_d = MUL2;
      MUL2: if (lat_done)  state_d = OUT;
      OUT:  if (out_ready) state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      active_q    <= 1'b0;
      step_q      <= '0;
      lat_q       <= '0;
      cfg_drift_q <= '0;
      cfg_vol_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)
        lat_q <= '0;
      else if (state_q == MUL1 || state_q == MUL2)
        lat_q <= lat_q + 1'b1;

      if (cfg_we && start_ready) begin
        cfg_drift_q <= cfg_drift;
        cfg_vol_q   <= cfg_vol;
      end

      if (start_fire) begin
        active_q <= 1'b1;
        step_q   <= '0;
      end else if (out_fire) begin
        if (out_last) begin
          active_q <= 1'b0;
          step_q   <= '0;
        end else begin
          step_q <= step_q + 1'b1;
        end
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [WIDTH-1:0] lane_s_q, s_out_q, z_q;
    logic signed [WIDTH-1:0] z_mul, p1, inc, p2, s_next;

    // The draw is fed straight from the port in the handshake cycle and from
    // the captured copy afterwards, so the first product is ready by MUL2.
    assign z_mul = (state_q == IDLE) ? z[i*WIDTH +: WIDTH] : z_q;
    assign inc   = cfg_drift_q + p1;

    gbm_fx_mul #(.WIDTH(WIDTH), .QFRAC(QFRAC), .MUL_LAT(MUL_LAT)) u_mul_vol (
      .clk (clk),
      .a   (cfg_vol_q),
      .b   (z_mul),
      .p   (p1)
    );

    gbm_fx_mul #(.WIDTH(WIDTH), .QFRAC(QFRAC), .MUL_LAT(MUL_LAT)) u_mul_s (
      .clk (clk),
      .a   (lane_s_q),
      .b   (inc),
      .p   (p2)
    );

    always_ff @(posedge clk) begin
      if (z_fire) z_q <= z[i*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        lane_s_q <= '0;
        s_out_q  <= '0;
      end else begin
        if (start_fire)    lane_s_q <= s0[i*WIDTH +: WIDTH];
        else if (out_fire) lane_s_q <= s_out_q;
        if (capture)       s_out_q  <= s_next;
      end
    end

`ifdef GBM_SAT_EN
    localparam logic signed [WIDTH:0] MAX_POS = {2'b00, {(WIDTH-1){1'b1}}};
    logic signed [WIDTH:0] sum;
    logic                  hit;
    logic                  sat_q;

    // One guard bit exposes overflow past either end of the word.
    assign sum = {lane_s_q[WIDTH-1], lane_s_q} + {p2[WIDTH-1], p2};

    always_comb begin
      s_next = sum[WIDTH-1:0];
      hit    = 1'b0;
      if (sum < 0) begin
        s_next = '0;
        hit    = 1'b1;
      end else if (sum > MAX_POS) begin
        s_next = MAX_POS[WIDTH-1:0];
        hit    = 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst || start_fire) sat_q <= 1'b0;
      else if (capture && hit) sat_q <= 1'b1;
    end

    assign sat_flag[i] = sat_q;
`else
    assign s_next      = lane_s_q + p2;
    assign sat_flag[i] = 1'b0;
`endif

    assign s_out[i*WIDTH +: WIDTH] = s_out_q;
  end
endmodule

// File: tb/tb_gbm_path_engine.sv
// tb_gbm_path_engine -- directed scoreboard bench for gbm_path_engine.
// Stimulus tasks push hand-computed expected outputs into a queue; a monitor
// pops and compares on every output handshake.
`timescale 1ns/1ps
module tb_gbm_path_engine;
  import gbm_pkg::*;

  localparam int WIDTH   = 32;
  localparam int QFRAC   = 16;
  localparam int LANES   = 4;
  localparam int N_STEPS = 8;
  localparam int MUL_LAT = 2;
  localparam int SW      = $clog2(N_STEPS);
  localparam int LAT     = 2*MUL_LAT + 1;

  localparam word_t Z_M1 = 32'hFFFF0000;
  localparam word_t Z_M2 = 32'hFFFE0000;
  localparam word_t Z_P1 = 32'h00010000;
  localparam word_t S100 = 32'h00640000;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   cfg_we = 1'b0;
  logic [WIDTH-1:0]       cfg_drift = '0, cfg_vol = '0;
  logic                   start_valid = 1'b0, start_ready;
  logic [LANES*WIDTH-1:0] s0 = '0;
  logic                   z_valid = 1'b0, z_ready;
  logic [LANES*WIDTH-1:0] z = '0;
  logic                   out_valid, out_ready = 1'b1;
  logic [LANES*WIDTH-1:0] s_out;
  logic [SW-1:0]          out_step;
  logic                   out_last, busy;
  logic [LANES-1:0]       sat_flag;

  gbm_path_engine #(
    .WIDTH(WIDTH), .QFRAC(QFRAC), .LANES(LANES),
    .N_STEPS(N_STEPS), .MUL_LAT(MUL_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_drift(cfg_drift), .cfg_vol(cfg_vol),
    .start_valid(start_valid), .start_ready(start_ready), .s0(s0),
    .z_valid(z_valid), .z_ready(z_ready), .z(z),
    .out_valid(out_valid), .out_ready(out_ready), .s_out(s_out),
    .out_step(out_step), .out_last(out_last),
    .busy(busy), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    lane_vec_t        s;
    logic [SW-1:0]    step;
    logic             last;
    logic [LANES-1:0] sat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic lane_vec_t mk(input word_t l0, input word_t l1, input word_t l2, input word_t l3);
    return {l3, l2, l1, l0};
  endfunction

  // Monitor: compare every output handshake against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      exp_t e;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got step %0d want none", out_step);
      end else begin
        e = sb.pop_front();
        check("s_out",    s_out,    e.s);
        check("out_step", out_step, e.step);
        check("out_last", out_last, e.last);
        check("sat_flag", sat_flag, e.sat);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"},   out_valid,   1'b0);
    check({tag, "_start_ready"}, start_ready, 1'b1);
    check({tag, "_z_ready"},     z_ready,     1'b0);
    check({tag, "_busy"},        busy,        1'b0);
    check({tag, "_s_out"},       s_out,       '0);
    check({tag, "_out_step"},    out_step,    '0);
    check({tag, "_out_last"},    out_last,    1'b0);
    check({tag, "_sat_flag"},    sat_flag,    '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    check_reset_state("reset");
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic configure(input word_t drift, input word_t vol);
    cfg_we = 1'b1;
    cfg_drift = drift;
    cfg_vol = vol;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic start_path(input lane_vec_t v);
    int n = 0;
    s0 = v;
    start_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (start_ready) break;
      if (++n > 50) begin
        check("start_timeout", 1'b0, 1'b1);
        break;
      end
    end
    tick();
    start_valid = 1'b0;
  endtask

  // Issue one z handshake; returns after the handshake edge (+1).
  task automatic z_handshake(input lane_vec_t zv);
    int n = 0;
    z = zv;
    z_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (z_ready) break;
      if (++n > 50) begin
        check("z_ready_timeout", 1'b0, 1'b1);
        break;
      end
    end
    tick();
    z_valid = 1'b0;
  endtask

  // One full step: push expectation, handshake z, check latency,
  // optionally stall the output for `stall` cycles, then complete it.
  task automatic do_step(input lane_vec_t zv, input lane_vec_t exp_s, input int step,
                         input logic [LANES-1:0] exp_sat, input int stall);
    exp_t e;
    int   lat = 1;
    e.s = exp_s;
    e.step = SW'(step);
    e.last = (step == N_STEPS - 1);
    e.sat = exp_sat;
    sb.push_back(e);
    out_ready = (stall == 0);
    z_handshake(zv);
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    check("latency", lat, LAT);
    if (stall > 0) begin
      for (int k = 0; k < stall; k++) begin
        @(negedge clk);
        check("stall_valid",   out_valid, 1'b1);
        check("stall_s_out",   s_out,     exp_s);
        check("stall_step",    out_step,  SW'(step));
        check("stall_z_ready", z_ready,   1'b0);
      end
      tick();
      out_ready = 1'b1;
    end
    tick();
  endtask

  initial begin
    lane_vec_t exp_v;
    logic [LANES-1:0] exp_sat;

    // ---- reset, then z_valid with no active path is ignored
    do_reset();
    z = mk(Z_M1, Z_M1, Z_M1, Z_M1);
    z_valid = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    check("idle_z_ready", z_ready, 1'b0);
    check("idle_busy",    busy,    1'b0);
    z_valid = 1'b0;

    // ---- zero drift/vol: price never moves, out_last only on final step
    configure('0, '0);
    start_path(mk(S100, S100, S100, S100));
    for (int i = 0; i < N_STEPS; i++) begin
      do_step(mk(word_t'(i << 16), Z_M1, Z_P1, 32'h12345678),
              mk(S100, S100, S100, S100), i, '0, 0);
    end
    check("path_end_start_ready", start_ready, 1'b1);
    check("path_end_z_ready",     z_ready,     1'b0);

    // ---- vol = 0.2, mixed draws per lane; two steps then reset in MUL2
    do_reset();
    configure('0, 32'h00003333);
    start_path(mk(S100, S100, S100, S100));
    do_step(mk(Z_M1, '0, Z_P1, Z_M2),
            mk(32'h00500014, S100, 32'h0077FFEC, 32'h003C0028), 0, '0, 0);

    // config write and start attempt mid-path must have no effect
    cfg_we = 1'b1;
    cfg_vol = 32'h00020000;
    start_valid = 1'b1;
    s0 = '0;
    check("midpath_start_ready", start_ready, 1'b0);
    tick();
    cfg_we = 1'b0;
    start_valid = 1'b0;

    do_step(mk(Z_M1, '0, Z_P1, '0),
            mk(32'h00400020, S100, 32'h008FFFD0, 32'h003C0028), 1, '0, 5);
    check("step_advanced", out_step, SW'(2));

    // reset landing in MUL2 discards the in-flight step
    z_handshake(mk(Z_M1, Z_M1, Z_M1, Z_M1));
    for (int k = 0; k < MUL_LAT; k++) tick();
    check("mul2_busy",      busy,      1'b1);
    check("mul2_out_valid", out_valid, 1'b0);
    rst = 1'b1;
    tick();
    check_reset_state("mid_rst");
    rst = 1'b0;
    for (int k = 0; k < LAT + 2; k++) tick();
    check("post_rst_no_output", out_valid, 1'b0);

    // ---- large vol drives S' negative: clamp or wrap
    do_reset();
    configure('0, 32'h00020000);
    start_path(mk(S100, S100, S100, S100));
`ifdef GBM_SAT_EN
    exp_v = mk('0, '0, S100, '0);
    exp_sat = 4'b1011;
`else
    exp_v = mk(32'hFF9C0000, 32'hFF9C0000, S100, 32'hFF9C0000);
    exp_sat = 4'b0000;
`endif
    do_step(mk(Z_M1, Z_M1, '0, Z_M1), exp_v, 0, exp_sat, 0);
    check("sat_sticky", sat_flag, exp_sat);

    // ---- pure drift of 1/16 on differing initial prices
    do_reset();
    configure(32'h00001000, '0);
    start_path(mk(S100, 32'h00010000, '0, S100));
    do_step(mk(Z_P1, Z_M1, Z_M2, '0),
            mk(32'h006A4000, 32'h00011000, '0, 32'h006A4000), 0, '0, 0);

    for (int k = 0; k < 4; k++) tick();
    check("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gbm_path_engine.md
GBM_PATH_ENGINE -- requirements
Module: gbm_path_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 32, signed fixed-point word width.
REQ-002 SHALL have parameter QFRAC, default 16, fraction bits (Q16.16 at defaults).
REQ-003 SHALL have parameter LANES, default 4, independent paths stepped in lockstep.
REQ-004 SHALL have parameter N_STEPS, default 64, time steps per path, >=2.
REQ-005 SHALL have parameter MUL_LAT, default 2, register stages per multiplier, >=1.
REQ-006 SHALL have ports: clk in 1 clock; rst in 1 reset, synchronous and active-high (one clock domain).
REQ-007 SHALL have ports: cfg_we in 1 config write; cfg_drift in WIDTH r*dt; cfg_vol in WIDTH sigma*sqrt(dt).
REQ-008 SHALL have ports: start_valid in 1; start_ready out 1; s0 in LANES*WIDTH initial prices.
REQ-009 SHALL have ports: z_valid in 1; z_ready out 1; z in LANES*WIDTH normal draws.
REQ-010 SHALL have ports: out_valid out 1; out_ready in 1; s_out out LANES*WIDTH; out_step out $clog2(N_STEPS); out_last out 1.
REQ-011 SHALL have ports: busy out 1 (state != IDLE); sat_flag out LANES, sticky per lane.

Function
REQ-012 SHALL use FSM states IDLE, MUL1, MUL2, OUT. Transitions: IDLE->MUL1 on z handshake; MUL1->MUL2 after MUL_LAT cycles; MUL2->OUT after MUL_LAT cycles; OUT->IDLE on output handshake.
REQ-013 SHALL accept cfg_we only in IDLE with no path active; otherwise ignore it.
REQ-014 SHALL assert start_ready only in IDLE with no path active; the start handshake loads s0 into lane state, clears step count and sat_flag.
REQ-015 SHALL assert z_ready only in IDLE with a path active; exactly N_STEPS z handshakes per path.
REQ-016 SHALL compute per lane inc = cfg_drift + ((cfg_vol*z)>>>QFRAC), then S' = S + ((S*inc)>>>QFRAC), with 2*WIDTH-bit products and arithmetic-shift truncation.
REQ-017 SHALL assert out_valid exactly 2*MUL_LAT+1 cycles after the z handshake.
REQ-018 SHALL hold s_out, out_step and out_last stable while out_valid=1 and out_ready=0.
REQ-019 SHALL write S' into lane state and increment step on the output handshake. out_step = 0..N_STEPS-1. out_last=1 at step N_STEPS-1; that handshake ends the path.
REQ-020 SHALL ignore start_valid during an active path and ignore z_valid when no path is active.

Reset
REQ-021 On rst: state=IDLE, no path active, out_valid=0, start_ready=1, z_ready=0, busy=0, s_out=0, out_step=0, out_last=0, sat_flag=0, cfg registers=0. Applies mid-path; the in-flight step is discarded.

Configuration
REQ-022 With GBM_SAT_EN defined: S'<0 clamps to 0, S' above max positive clamps to max positive, and either clamp sets that lane's sat_flag.
REQ-023 Without GBM_SAT_EN: S' wraps to WIDTH bits; sat_flag is tied to 0.

Structure
REQ-024 Package gbm_pkg SHALL hold the fixed-point word typedef, the lane-vector typedef, the FSM state enum, and the saturation-limit constants.
REQ-025 Sub-module gbm_fx_mul (signed WIDTH x WIDTH, MUL_LAT-stage pipelined, shift by QFRAC) SHALL be instantiated per lane for both multiplies.

Verification
REQ-026 s0=0x00640000, drift=0, vol=0, any z: all N_STEPS outputs = 0x00640000, out_last only at step N_STEPS-1.
REQ-027 s0=0x00640000, drift=0, vol=0x00003333, z=0xFFFF0000: first s_out = 0x00500014.
REQ-028 Hold out_ready=0 for 5 cycles while out_valid=1: s_out stable, z_ready=0; then one handshake advances out_step by 1.
REQ-029 vol=0x00020000, z=0xFFFF0000, s0=0x00640000: with GBM_SAT_EN, s_out=0 and sat_flag set; without it, s_out=0xFF9C0000.
REQ-030 rst asserted in MUL2: next cycle out_valid=0, start_ready=1. cfg_we or start_valid during a path has no effect.
